alu32_pipe: RTL and testbench



---
 rtl/alu32_pipe_if.sv | 25 ++
 rtl/alu32_pipe.sv | 78 +++++++
 tb/tb_alu32_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu32_pipe_if.sv
// Operation/result bundle between decode/forwarding logic and the execute-stage ALU.
// The master drives one operation per enabled cycle; the slave returns result and flags.
interface alu32_pipe_if;
  logic        en;
  logic [1:0]  ctrl;
  logic [15:0] imm;
  logic [31:0] a;
  logic [31:0] b;
  logic        src;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        overflow;
  logic        carryOut;

  modport master (
    output en, ctrl, imm, a, b, src,
    input  result, zero, negative, overflow, carryOut
  );

  modport slave (
    input  en, ctrl, imm, a, b, src,
    output result, zero, negative, overflow, carryOut
  );
endinterface

// File: rtl/alu32_pipe.sv
// Registered execute-stage ALU: captures operation and operands each enabled cycle,
// then derives result and status flags combinationally from the captured values.
module alu32_pipe (
  input  logic         clk,
  input  logic         rst_n,
  alu32_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_SLT = 2'b11
  } AluOp;

  AluOp        ctrlQ;
  logic [15:0] immQ;
  logic [31:0] aQ;
  logic [31:0] bQ;
  logic        srcQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlQ <= OP_ADD;
      immQ  <= '0;
      aQ    <= '0;
      bQ    <= '0;
      srcQ  <= 1'b0;
    end else if (bus.en) begin
      ctrlQ <= AluOp'(bus.ctrl);
      immQ  <= bus.imm;
      aQ    <= bus.a;
      bQ    <= bus.b;
      srcQ  <= bus.src;
    end
  end

  logic [31:0] opB;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        carry;
  logic        subtract;
  logic        addOvf;
  logic        lessThan;
  logic [31:0] resultC;
  logic        overflowC;
  logic        carryC;

  // SLT reuses the subtract path; its answer is N xor V of a - opB.
  always_comb begin
    opB       = srcQ ? {{16{immQ[15]}}, immQ} : bQ;
    subtract  = (ctrlQ == OP_SUB) || (ctrlQ == OP_SLT);
    addend    = subtract ? ~opB : opB;
    {carry, sum} = {1'b0, aQ} + {1'b0, addend} + {32'b0, subtract};
    addOvf    = (aQ[31] == addend[31]) && (sum[31] != aQ[31]);
    lessThan  = sum[31] ^ addOvf;
    resultC   = sum;
    overflowC = 1'b0;
    carryC    = 1'b0;
    case (ctrlQ)
      OP_ADD, OP_SUB: begin
        resultC   = sum;
        overflowC = addOvf;
        carryC    = carry;
      end
      OP_AND: resultC = aQ & opB;
      OP_SLT: resultC = {31'b0, lessThan};
      default: resultC = sum;
    endcase
  end

  assign bus.result   = resultC;
  assign bus.zero     = (resultC == 32'b0);
  assign bus.negative = resultC[31];
  assign bus.overflow = overflowC;
  assign bus.carryOut = carryC;

endmodule

// File: tb/tb_alu32_pipe.sv
// Self-checking bench for alu32_pipe: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model of the execute stage.
module tb_alu32_pipe;

  logic clk;
  logic rst_n;
  alu32_pipe_if bus ();

  alu32_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Model of what the stage registers currently hold.
  logic [1:0]  mCtrl;
  logic [15:0] mImm;
  logic [31:0] mA;
  logic [31:0] mB;
  logic        mSrc;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    mCtrl = 2'd0; mImm = 16'd0; mA = 32'd0; mB = 32'd0; mSrc = 1'b0;
  endtask

  task automatic modelCapture();
    mCtrl = bus.ctrl; mImm = bus.imm; mA = bus.a; mB = bus.b; mSrc = bus.src;
  endtask

  task automatic checkAll(input string tag);
    longint sa, sb, wide;
    longint unsigned ua, ub;
    logic [31:0] opb, res;
    logic ovf, cy;
    opb = mSrc ? 32'($signed(mImm)) : mB;
    sa  = longint'($signed(mA));
    sb  = longint'($signed(opb));
    ua  = longint'(mA);
    ub  = longint'(opb);
    ovf = 1'b0;
    cy  = 1'b0;
    case (mCtrl)
      2'd0: begin
        res  = mA + opb;
        wide = sa + sb;
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        cy   = (ua + ub) > 64'hFFFF_FFFF;
      end
      2'd1: begin
        res  = mA - opb;
        wide = sa - sb;
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        cy   = (ua >= ub);
      end
      2'd2: res = mA & opb;
      default: res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    checkOutput({tag, ".result"},   bus.result,            res);
    checkOutput({tag, ".zero"},     32'(bus.zero),         32'(res == 32'd0));
    checkOutput({tag, ".negative"}, 32'(bus.negative),     32'(res[31]));
    checkOutput({tag, ".overflow"}, 32'(bus.overflow),     32'(ovf));
    checkOutput({tag, ".carryOut"}, 32'(bus.carryOut),     32'(cy));
  endtask

  task automatic driveInputs(input logic en, input logic [1:0] ctrl, input logic [15:0] imm,
                             input logic [31:0] a, input logic [31:0] b, input logic src);
    bus.en = en; bus.ctrl = ctrl; bus.imm = imm; bus.a = a; bus.b = b; bus.src = src;
  endtask

  task automatic applyStimulus(input string tag, input logic en, input logic [1:0] ctrl,
                               input logic [15:0] imm, input logic [31:0] a,
                               input logic [31:0] b, input logic src);
    @(negedge clk);
    driveInputs(en, ctrl, imm, a, b, src);
    @(posedge clk);
    if (en && rst_n) modelCapture();
    #1;
    checkAll(tag);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    modelClear();
    driveInputs(1'b1, 2'd1, 16'h1234, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
    #3;
    checkAll("resetInit");
    @(posedge clk); #1;
    checkAll("resetEdge");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("addOvf",   1'b1, 2'b00, 16'h0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("addOvf.fixed", bus.result, 32'h8000_0000);
    applyStimulus("addCarry", 1'b1, 2'b00, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("addCarry.fixed", 32'({bus.carryOut, bus.zero}), 32'b11);
    applyStimulus("subImm",   1'b1, 2'b01, 16'hFFFF, 32'h0000_0005, 32'h0000_0000, 1'b1);
    checkOutput("subImm.fixed", bus.result, 32'd6);
    applyStimulus("subEqual", 1'b1, 2'b01, 16'h0000, 32'h0000_0003, 32'h0000_0003, 1'b0);
    applyStimulus("sltNeg",   1'b1, 2'b11, 16'h0000, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    checkOutput("sltNeg.fixed", bus.result, 32'd1);
    applyStimulus("sltPos",   1'b1, 2'b11, 16'h0000, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("and",      1'b1, 2'b10, 16'h0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    checkOutput("and.fixed", bus.result, 32'hF000_F000);
    applyStimulus("sltImm",   1'b1, 2'b11, 16'h8000, 32'hFFFF_0000, 32'h0000_0000, 1'b1);

    // Hold for three cycles, then confirm the new op lands exactly one edge later.
    applyStimulus("holdLoad", 1'b1, 2'b00, 16'h0000, 32'd2, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold", 1'b0, 2'($urandom()), 16'($urandom()), $urandom(), $urandom(),
                    1'($urandom()));
      checkOutput("hold.fixed", bus.result, 32'd5);
    end
    @(negedge clk);
    driveInputs(1'b1, 2'b01, 16'h0000, 32'd10, 32'd4, 1'b0);
    #1;
    checkOutput("preEdge.result", bus.result, 32'd5);
    @(posedge clk);
    modelCapture();
    #1;
    checkAll("postEdge");
    checkOutput("postEdge.fixed", bus.result, 32'd6);

    // Asynchronous reset mid-cycle discards the in-flight op.
    @(posedge clk);
    #($urandom_range(1, 8));
    rst_n = 1'b0;
    modelClear();
    #1;
    checkAll("resetMid");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("afterReset", 1'b1, 2'b00, 16'h0000, 32'd7, 32'd8, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelClear();
        #1;
        checkAll("resetRand");
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus("rand", ($urandom_range(0, 4) != 0), 2'($urandom()), 16'($urandom()),
                    pickOperand(), pickOperand(), 1'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
